// File: rtl/tdc_frame_rx_pkg.sv
// rtl/tdc_frame_rx_pkg.sv - shared types and constants for the TDC frame receiver
package tdc_frame_rx_pkg;

    localparam int TDC_DATA_W = 10;
    localparam int TDC_INT_W  = 5;

    localparam int ERR_MISMATCH = 0;
    localparam int ERR_OVERFLOW = 1;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_WAIT    = 5'b00010,
        ST_COLLECT = 5'b00100,
        ST_DRAIN   = 5'b01000,
        ST_OUT     = 5'b10000
    } state_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

endpackage

// File: rtl/tdc_echo_max.sv
// rtl/tdc_echo_max.sv - registered running maximum of (intensity, tof), ties keep the first
module tdc_echo_max #(
    parameter int DATA_W = 10,
    parameter int INT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] in_tof,
    input  logic [INT_W-1:0]  in_int,
    output logic [DATA_W-1:0] best_tof,
    output logic [INT_W-1:0]  best_int
);

    // have_q lets a zero-intensity first beat still claim the slot
    logic have_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            have_q   <= 1'b0;
            best_tof <= '0;
            best_int <= '0;
        end else if (en && (!have_q || (in_int > best_int))) begin
            have_q   <= 1'b1;
            best_tof <= in_tof;
            best_int <= in_int;
        end
    end

endmodule

// File: rtl/tdc_frame_rx.sv
// rtl/tdc_frame_rx.sv - collects one TDC measurement frame and presents it as a record
module tdc_frame_rx
    import tdc_frame_rx_pkg::*;
#(
    parameter int DATA_W   = TDC_DATA_W,
    parameter int INT_W    = TDC_INT_W,
    parameter int MAX_ECHO = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tdc_int,
    input  logic [DATA_W-1:0]            s_data,
    input  logic [INT_W-1:0]             s_int,
    input  logic [1:0]                   s_num,
    input  logic                         s_last,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [MAX_ECHO*DATA_W-1:0]   m_tof,
    output logic [MAX_ECHO*INT_W-1:0]    m_int,
    output logic [DATA_W-1:0]            m_best_tof,
    output logic [INT_W-1:0]             m_best_int,
    output logic [1:0]                   m_num,
    output logic [1:0]                   m_err,
    output logic [15:0]                  m_frame_cnt,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int          TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [1:0]  MAX_IDX = 2'(MAX_ECHO);

    state_t                       state_q, state_d;
    logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
    logic [1:0]                   idx_q;
    logic [2:0]                   rcv_cnt_q, rcv_cnt_d;
    logic [1:0]                   exp_q, exp_d;
    logic [1:0]                   err_q;
    logic [15:0]                  frame_cnt_q;
    logic [MAX_ECHO*DATA_W-1:0]   tof_q;
    logic [MAX_ECHO*INT_W-1:0]    int_q;
    logic                         s_ready_q, m_valid_q;

    logic beat, first, store, drop, close, mismatch, hs_out;

    assign beat = s_valid && s_ready_q;

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        first    = 1'b0;
        store    = 1'b0;
        drop     = 1'b0;
        close    = 1'b0;
        hs_out   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // a beat takes priority over a same-cycle interrupt
                if (beat) begin
                    first   = 1'b1;
                    store   = 1'b1;
                    close   = s_last;
                    state_d = s_last ? ST_OUT : ST_COLLECT;
                end else if (tdc_int) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (beat) begin
                    first   = 1'b1;
                    store   = 1'b1;
                    close   = s_last;
                    state_d = s_last ? ST_OUT : ST_COLLECT;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_COLLECT: begin
                if (beat) begin
                    if (idx_q == MAX_IDX) drop = 1'b1;
                    else                  store = 1'b1;
                    if (s_last) begin
                        close   = 1'b1;
                        state_d = ST_OUT;
                    end else if (idx_q == MAX_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && s_last) begin
                    close   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    hs_out  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rcv_cnt_d = beat ? sat_inc3(rcv_cnt_q) : rcv_cnt_q;
        exp_d     = first ? s_num : exp_q;
        mismatch  = close && (rcv_cnt_d != {1'b0, exp_d});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            idx_q       <= '0;
            rcv_cnt_q   <= '0;
            exp_q       <= '0;
            err_q       <= '0;
            frame_cnt_q <= '0;
            tof_q       <= '0;
            int_q       <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            s_ready_q <= (state_d != ST_OUT);
            m_valid_q <= (state_d == ST_OUT);
            if (hs_out) begin
                idx_q       <= '0;
                rcv_cnt_q   <= '0;
                exp_q       <= '0;
                err_q       <= '0;
                tof_q       <= '0;
                int_q       <= '0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
                rcv_cnt_q <= rcv_cnt_d;
                exp_q     <= exp_d;
                // store only fires below MAX_IDX, so idx saturates there
                if (store) begin
                    idx_q <= idx_q + 2'd1;
                    for (int i = 0; i < MAX_ECHO; i++) begin
                        if (idx_q == 2'(i)) begin
                            tof_q[i*DATA_W +: DATA_W] <= s_data;
                            int_q[i*INT_W +: INT_W]   <= s_int;
                        end
                    end
                end
                if (drop)     err_q[ERR_OVERFLOW] <= 1'b1;
                if (mismatch) err_q[ERR_MISMATCH] <= 1'b1;
            end
        end
    end

    tdc_echo_max #(
        .DATA_W (DATA_W),
        .INT_W  (INT_W)
    ) u_echo_max (
        .clk      (clk),
        .rst      (rst),
        .clr      (hs_out),
        .en       (store),
        .in_tof   (s_data),
        .in_int   (s_int),
        .best_tof (m_best_tof),
        .best_int (m_best_int)
    );

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_tof       = tof_q;
    assign m_int       = int_q;
    assign m_num       = idx_q;
    assign m_err       = err_q;
    assign m_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdc_frame_rx.sv
// tb/tb_tdc_frame_rx.sv - directed self-checking bench for tdc_frame_rx
module tb_tdc_frame_rx;

    localparam int DATA_W = 10;
    localparam int INT_W  = 5;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tdc_int = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic [INT_W-1:0]  s_int = '0;
    logic [1:0]        s_num = '0;
    logic              s_last = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [3*DATA_W-1:0] m_tof;
    logic [3*INT_W-1:0]  m_int;
    logic [DATA_W-1:0] m_best_tof;
    logic [INT_W-1:0]  m_best_int;
    logic [1:0]        m_num;
    logic [1:0]        m_err;
    logic [15:0]       m_frame_cnt;
    logic              m_valid;
    logic              m_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdc_frame_rx #(
        .DATA_W   (DATA_W),
        .INT_W    (INT_W),
        .MAX_ECHO (3),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tdc_int     (tdc_int),
        .s_data      (s_data),
        .s_int       (s_int),
        .s_num       (s_num),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_tof       (m_tof),
        .m_int       (m_int),
        .m_best_tof  (m_best_tof),
        .m_best_int  (m_best_int),
        .m_num       (m_num),
        .m_err       (m_err),
        .m_frame_cnt (m_frame_cnt),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] tof, input logic [INT_W-1:0] iv,
                             input logic [1:0] num, input logic last);
        s_valid = 1'b1;
        s_data  = tof;
        s_int   = iv;
        s_num   = num;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic consume();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_num", 64'(m_num), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        check("rst_frame_cnt", 64'(m_frame_cnt), 64'd0);
        check("rst_m_tof", 64'(m_tof), 64'd0);
        check("rst_best_tof", 64'(m_best_tof), 64'd0);

        // three-beat frame with a tie on intensity
        send_beat(10'd100, 5'd4, 2'd3, 1'b0);
        send_beat(10'd200, 5'd9, 2'd3, 1'b0);
        check("f3_valid_early", 64'(m_valid), 64'd0);
        send_beat(10'd300, 5'd9, 2'd3, 1'b1);
        check("f3_valid", 64'(m_valid), 64'd1);
        check("f3_s_ready", 64'(s_ready), 64'd0);
        check("f3_num", 64'(m_num), 64'd3);
        check("f3_tof", 64'(m_tof), 64'({10'd300, 10'd200, 10'd100}));
        check("f3_int", 64'(m_int), 64'({5'd9, 5'd9, 5'd4}));
        check("f3_best_tof", 64'(m_best_tof), 64'd200);
        check("f3_best_int", 64'(m_best_int), 64'd9);
        check("f3_err", 64'(m_err), 64'd0);
        consume();
        check("f3_valid_after", 64'(m_valid), 64'd0);
        check("f3_ready_after", 64'(s_ready), 64'd1);
        check("f3_cnt", 64'(m_frame_cnt), 64'd1);
        check("f3_cleared_tof", 64'(m_tof), 64'd0);
        check("f3_cleared_num", 64'(m_num), 64'd0);

        // single full-scale beat
        send_beat(10'h3FF, 5'd31, 2'd1, 1'b1);
        check("f1_valid", 64'(m_valid), 64'd1);
        check("f1_num", 64'(m_num), 64'd1);
        check("f1_tof", 64'(m_tof), 64'h3FF);
        check("f1_int", 64'(m_int), 64'd31);
        check("f1_best_tof", 64'(m_best_tof), 64'h3FF);
        check("f1_best_int", 64'(m_best_int), 64'd31);
        check("f1_err", 64'(m_err), 64'd0);
        consume();
        check("f1_cnt", 64'(m_frame_cnt), 64'd2);

        // advertised three, two delivered
        send_beat(10'd10, 5'd1, 2'd3, 1'b0);
        send_beat(10'd20, 5'd2, 2'd3, 1'b1);
        check("mm_valid", 64'(m_valid), 64'd1);
        check("mm_num", 64'(m_num), 64'd2);
        check("mm_err", 64'(m_err), 64'd1);
        check("mm_tof", 64'(m_tof), 64'({10'd0, 10'd20, 10'd10}));
        check("mm_best_tof", 64'(m_best_tof), 64'd20);
        consume();

        // four beats: fourth dropped even though it is the strongest
        send_beat(10'd1, 5'd1, 2'd3, 1'b0);
        send_beat(10'd2, 5'd5, 2'd3, 1'b0);
        send_beat(10'd3, 5'd2, 2'd3, 1'b0);
        send_beat(10'd4, 5'd30, 2'd3, 1'b1);
        check("ov_valid", 64'(m_valid), 64'd1);
        check("ov_num", 64'(m_num), 64'd3);
        check("ov_err", 64'(m_err), 64'd3);
        check("ov_tof", 64'(m_tof), 64'({10'd3, 10'd2, 10'd1}));
        check("ov_int", 64'(m_int), 64'({5'd2, 5'd5, 5'd1}));
        check("ov_best_tof", 64'(m_best_tof), 64'd2);
        check("ov_best_int", 64'(m_best_int), 64'd5);
        consume();
        check("ov_cnt", 64'(m_frame_cnt), 64'd4);

        // five equal beats: drain path, ties keep slot 0
        send_beat(10'd5, 5'd3, 2'd2, 1'b0);
        send_beat(10'd6, 5'd3, 2'd2, 1'b0);
        send_beat(10'd7, 5'd3, 2'd2, 1'b0);
        send_beat(10'd8, 5'd3, 2'd2, 1'b0);
        check("dr_valid_early", 64'(m_valid), 64'd0);
        send_beat(10'd9, 5'd3, 2'd2, 1'b1);
        check("dr_valid", 64'(m_valid), 64'd1);
        check("dr_num", 64'(m_num), 64'd3);
        check("dr_err", 64'(m_err), 64'd3);
        check("dr_tof", 64'(m_tof), 64'({10'd7, 10'd6, 10'd5}));
        check("dr_best_tof", 64'(m_best_tof), 64'd5);
        consume();

        // timeout with no beats
        tdc_int = 1'b1;
        step();
        tdc_int = 1'b0;
        repeat (TO - 1) step();
        check("to_valid_early", 64'(m_valid), 64'd0);
        step();
        check("to_valid", 64'(m_valid), 64'd1);
        check("to_num", 64'(m_num), 64'd0);
        check("to_err", 64'(m_err), 64'd0);
        check("to_tof", 64'(m_tof), 64'd0);
        consume();
        check("to_cnt", 64'(m_frame_cnt), 64'd6);

        // beat lands at counter value TIMEOUT-2
        tdc_int = 1'b1;
        step();
        tdc_int = 1'b0;
        repeat (TO - 2) step();
        check("tl_valid_early", 64'(m_valid), 64'd0);
        send_beat(10'd50, 5'd7, 2'd1, 1'b1);
        check("tl_valid", 64'(m_valid), 64'd1);
        check("tl_num", 64'(m_num), 64'd1);
        check("tl_err", 64'(m_err), 64'd0);
        check("tl_tof", 64'(m_tof), 64'd50);
        consume();

        // interrupt and beat in the same idle cycle
        tdc_int = 1'b1;
        send_beat(10'd11, 5'd3, 2'd2, 1'b0);
        tdc_int = 1'b0;
        send_beat(10'd12, 5'd4, 2'd2, 1'b1);
        check("ib_valid", 64'(m_valid), 64'd1);
        check("ib_num", 64'(m_num), 64'd2);
        check("ib_err", 64'(m_err), 64'd0);
        check("ib_best_tof", 64'(m_best_tof), 64'd12);
        consume();
        check("ib_cnt", 64'(m_frame_cnt), 64'd8);

        // backpressure while upstream keeps offering
        send_beat(10'd77, 5'd6, 2'd1, 1'b1);
        s_valid = 1'b1;
        s_data  = 10'd99;
        s_int   = 5'd31;
        s_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 64'(m_valid), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_tof", 64'(m_tof), 64'd77);
            check("bp_num", 64'(m_num), 64'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        consume();
        check("bp_cnt", 64'(m_frame_cnt), 64'd9);
        check("bp_num_after", 64'(m_num), 64'd0);
        check("bp_valid_after", 64'(m_valid), 64'd0);

        // reset in the middle of a frame, with a beat offered during reset
        send_beat(10'd100, 5'd4, 2'd3, 1'b0);
        check("rm_num_partial", 64'(m_num), 64'd1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 10'd222;
        s_int   = 5'd20;
        s_last  = 1'b1;
        step();
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("rm_num", 64'(m_num), 64'd0);
        check("rm_cnt", 64'(m_frame_cnt), 64'd0);
        check("rm_s_ready", 64'(s_ready), 64'd1);
        check("rm_valid", 64'(m_valid), 64'd0);
        check("rm_tof", 64'(m_tof), 64'd0);
        check("rm_best_tof", 64'(m_best_tof), 64'd0);
        send_beat(10'd60, 5'd2, 2'd1, 1'b1);
        check("rm2_valid", 64'(m_valid), 64'd1);
        check("rm2_num", 64'(m_num), 64'd1);
        check("rm2_tof", 64'(m_tof), 64'd60);
        check("rm2_err", 64'(m_err), 64'd0);
        consume();
        check("rm2_cnt", 64'(m_frame_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
